// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-seg display; optional leading-zero blanking (SEG7_LZ_BLANK_EN).
// Latency: all pins registered, one cycle behind the cnt/idx scan state.
// No backpressure: free-running scan; the value is sampled once per frame into a shadow register.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  digit_data,
    output logic        digit_point,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   shadow_val, val_eff;
    logic [3:0]    shadow_dp, dp_eff;
    logic          load;
    logic          lit;
    logic          blank;
    logic [3:0]    an_nxt;
    logic [3:0]    data_nxt;

    // A frame starts whenever the scan sits at digit 0, cnt 0 while enabled.
    // The same edge loads the shadow, so digit 0 reads the inputs directly.
    always_comb begin
        load     = !enable || (cnt == '0 && idx == 2'd0);
        val_eff  = load ? value   : shadow_val;
        dp_eff   = load ? dp_mask : shadow_dp;
        cnt_nxt  = cnt;
        idx_nxt  = idx;
        if (!enable) begin
            cnt_nxt = '0;
            idx_nxt = 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            idx_nxt = idx + 2'd1;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
        lit      = enable && (32'(cnt) >= DEAD_CYCLES);
        data_nxt = val_eff[{idx, 2'b00} +: 4];
        an_nxt   = 4'b1111;
        if (lit && !blank)
            an_nxt = ~(4'b0001 << idx);
    end

`ifdef SEG7_LZ_BLANK_EN
    // Uses only the shadow, so blanking can change only at frame boundaries.
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd1:    blank = (shadow_val[15:4]  == 12'h000) && !shadow_dp[1];
            2'd2:    blank = (shadow_val[15:8]  == 8'h00)   && !shadow_dp[2];
            2'd3:    blank = (shadow_val[15:12] == 4'h0)    && !shadow_dp[3];
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            idx         <= 2'd0;
            shadow_val  <= 16'h0000;
            shadow_dp   <= 4'h0;
            an_n        <= 4'b1111;
            digit_data  <= 4'h0;
            digit_point <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            shadow_val  <= val_eff;
            shadow_dp   <= dp_eff;
            an_n        <= an_nxt;
            digit_data  <= data_nxt;
            digit_point <= ~dp_eff[idx];
            frame_done  <= enable && load;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: per-cycle scoreboard against a frame model plus table-driven frame checks.
// Honours SEG7_LZ_BLANK_EN when expecting anode patterns.
module tb_seg7_scan_ctrl;

    localparam int RD = 8;
    localparam int DC = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  digit_data;
    logic        digit_point;
    logic [3:0]  an_n;
    logic        frame_done;

    seg7_scan_ctrl #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .value(value), .dp_mask(dp_mask),
        .digit_data(digit_data), .digit_point(digit_point), .an_n(an_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic       fd;
        logic [3:0] data;
        logic       point;
        logic       chk_data;
    } exp_t;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [15:0] exp_data;   // nibble d = digit_data during slot d
        logic [3:0]  exp_point;  // bit d = digit_point during slot d
        logic [15:0] exp_an;     // nibble d = an_n during slot d LIT phase
    } vec_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_pos = 0;
    logic [15:0] m_val = 16'h0000;
    logic [3:0]  m_dp = 4'h0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

`ifdef SEG7_LZ_BLANK_EN
    function automatic logic blank_model(int d, logic [15:0] v, logic [3:0] p);
        logic z;
        z = 1'b1;
        for (int k = 3; k >= d; k--)
            if (v[k*4 +: 4] != 4'h0) z = 1'b0;
        return (d != 0) && z && !p[d];
    endfunction
`endif

    // One clock: predict the pins for this edge, push, clock, pop and compare.
    task automatic tick();
        exp_t e;
        int   d;
        int   c;
        logic bl;
        e = '{an: 4'hF, fd: 1'b0, data: 4'h0, point: 1'b1, chk_data: 1'b0};
        if (!enable) begin
            m_val = value;
            m_dp  = dp_mask;
            m_pos = 0;
        end else begin
            if (m_pos == 0) begin
                m_val = value;
                m_dp  = dp_mask;
                e.fd  = 1'b1;
            end
            d  = m_pos / RD;
            c  = m_pos % RD;
            bl = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
            bl = blank_model(d, m_val, m_dp);
`endif
            e.data     = m_val[d*4 +: 4];
            e.point    = ~m_dp[d];
            e.chk_data = 1'b1;
            if (c >= DC && !bl) e.an = ~(4'b0001 << d);
            m_pos = (m_pos + 1) % FRAME;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            chk("sb_an", 16'(an_n), 16'(e.an));
            chk("sb_frame_done", 16'(frame_done), 16'(e.fd));
            if (e.chk_data) begin
                chk("sb_data", 16'(digit_data), 16'(e.data));
                chk("sb_point", 16'(digit_point), 16'(e.point));
            end
        end
    endtask

    task automatic goto_pos(input int p);
        for (int i = 0; i < FRAME + 4 && m_pos != p; i++) tick();
        if (m_pos != p) begin
            n_cmp++; n_bad++;
            $display("FAIL goto_pos: got %0d want %0d", m_pos, p);
        end
    endtask

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 16'h1234, 4'b1111, 16'h7BDE};
        vecs[1] = '{16'hABCD, 4'b0101, 16'hABCD, 4'b1010, 16'h7BDE};
`ifdef SEG7_LZ_BLANK_EN
        vecs[2] = '{16'h0070, 4'b0000, 16'h0070, 4'b1111, 16'hFFDE};
        vecs[3] = '{16'h0000, 4'b0100, 16'h0000, 4'b1011, 16'hFBFE};
        vecs[4] = '{16'h000F, 4'b0000, 16'h000F, 4'b1111, 16'hFFFE};
`else
        vecs[2] = '{16'h0070, 4'b0000, 16'h0070, 4'b1111, 16'h7BDE};
        vecs[3] = '{16'h0000, 4'b0100, 16'h0000, 4'b1011, 16'h7BDE};
        vecs[4] = '{16'h000F, 4'b0000, 16'h000F, 4'b1111, 16'h7BDE};
`endif

        // Reset state while clocks run with reset held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", 16'(an_n), 16'hF);
        chk("rst_data", 16'(digit_data), 16'h0);
        chk("rst_point", 16'(digit_point), 16'h1);
        chk("rst_fd", 16'(frame_done), 16'h0);

        value   = 16'h1234;
        enable  = 1'b1;
        reset_n = 1'b1;
        tick();
        chk("first_fd", 16'(frame_done), 16'h1);
        chk("first_data", 16'(digit_data), 16'h4);
        chk("first_an_dead", 16'(an_n), 16'hF);

        // Table-driven frames: each vector loaded at a frame start, checked mid-LIT of each slot.
        foreach (vecs[v]) begin
            goto_pos(0);
            value   = vecs[v].value;
            dp_mask = vecs[v].dp;
            for (int i = 0; i < FRAME; i++) begin
                int p;
                int d;
                p = m_pos;
                d = p / RD;
                tick();
                if (p % RD == 4) begin
                    chk($sformatf("vec%0d_data_d%0d", v, d), 16'(digit_data), 16'(vecs[v].exp_data[d*4 +: 4]));
                    chk($sformatf("vec%0d_point_d%0d", v, d), 16'(digit_point), 16'(vecs[v].exp_point[d]));
                    chk($sformatf("vec%0d_an_d%0d", v, d), 16'(an_n), 16'(vecs[v].exp_an[d*4 +: 4]));
                end
            end
        end

        // Mid-frame value change must not appear until the next frame.
        goto_pos(0);
        value   = 16'h1234;
        dp_mask = 4'h0;
        goto_pos(9);
        value = 16'hABCD;
        for (int i = 0; i < FRAME; i++) begin
            int p;
            p = m_pos;
            tick();
            if (p == 12) chk("mid_d1", 16'(digit_data), 16'h3);
            if (p == 20) chk("mid_d2", 16'(digit_data), 16'h2);
            if (p == 28) chk("mid_d3", 16'(digit_data), 16'h1);
            if (p == 4)  chk("next_d0", 16'(digit_data), 16'hD);
        end

        // Enable drop during digit 2, then re-enable.
        goto_pos(2 * RD + 3);
        enable = 1'b0;
        tick();
        chk("dis_an", 16'(an_n), 16'hF);
        chk("dis_fd", 16'(frame_done), 16'h0);
        value = 16'h5678;
        repeat (5) tick();
        chk("dis_fd_hold", 16'(frame_done), 16'h0);
        enable = 1'b1;
        tick();
        chk("reen_fd", 16'(frame_done), 16'h1);
        chk("reen_data", 16'(digit_data), 16'h8);
        repeat (RD + 4) tick();
        chk("reen_d1", 16'(digit_data), 16'h7);

        // Asynchronous reset in digit 2 LIT phase.
        goto_pos(2 * RD + 5);
        tick();
        chk("pre_rst_an", 16'(an_n), 16'b1011);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_an", 16'(an_n), 16'hF);
        chk("arst_data", 16'(digit_data), 16'h0);
        chk("arst_point", 16'(digit_point), 16'h1);
        m_pos = 0;
        m_val = 16'h0000;
        m_dp  = 4'h0;
        sb.delete();
        value = 16'h4321;
        @(posedge clk);
        #1;
        chk("arst_hold_an", 16'(an_n), 16'hF);
        reset_n = 1'b1;
        tick();
        chk("post_rst_fd", 16'(frame_done), 16'h1);
        chk("post_rst_data", 16'(digit_data), 16'h1);
        repeat (FRAME + 3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
